// File: rtl/raster_stream_gen_pkg.sv
// Shared widths and helpers for the raster stream generator.
// Coordinate/pixel widths come from the network_params.h macros; fallback values apply when absent.
`ifndef SCREEN_X_BITWIDTH
`define SCREEN_X_BITWIDTH 9
`endif
`ifndef SCREEN_Y_BITWIDTH
`define SCREEN_Y_BITWIDTH 8
`endif
`ifndef CAMERA_PIXEL_BITWIDTH
`define CAMERA_PIXEL_BITWIDTH 11
`endif

package raster_stream_gen_pkg;

  localparam int X_W   = `SCREEN_X_BITWIDTH + 1;
  localparam int Y_W   = `SCREEN_Y_BITWIDTH + 1;
  localparam int PIX_W = `CAMERA_PIXEL_BITWIDTH + 1;

  typedef logic [X_W-1:0]   coord_x_t;
  typedef logic [Y_W-1:0]   coord_y_t;
  typedef logic [PIX_W-1:0] pixel_t;

  // True when value is representable as an unsigned number of the given width.
  function automatic bit fits_width(input int value, input int width);
    return (value >= 0) && (longint'(value) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/raster_stream_gen.sv
// Raster pixel stream generator: accepts upstream pixels in raster order and tags them
// with screen coordinates, inserting horizontal/vertical blanking and frame strobes.
//
// state  | meaning
// IDLE   | stopped, counters held at 0, waiting for enable
// ACTIVE | accepting pixels of the current line (ready=1)
// HBLANK | free-running blank cycles appended to a line
// VBLANK | free-running blank lines appended to a frame
module raster_stream_gen
  import raster_stream_gen_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     enable,
  input  pixel_t   pixel_in,
  input  logic     pixel_in_valid,
  output logic     pixel_in_ready,
  output coord_x_t screen_x,
  output coord_y_t screen_y,
  output pixel_t   pixel_out,
  output logic     pixel_valid,
  output logic     frame_start,
  output logic     frame_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HBLANK = 2'd2;
  localparam logic [1:0] S_VBLANK = 2'd3;

  localparam coord_x_t X_ACT_LAST   = coord_x_t'(SCREEN_W - 1);
  localparam coord_x_t X_LINE_LAST  = coord_x_t'(SCREEN_W + H_BLANK - 1);
  localparam coord_y_t Y_ACT_LAST   = coord_y_t'(SCREEN_H - 1);
  localparam coord_y_t Y_FRAME_LAST = coord_y_t'(SCREEN_H + V_BLANK - 1);
  localparam bit       HAS_HBLANK   = (H_BLANK > 0);
  localparam bit       HAS_VBLANK   = (V_BLANK > 0);

  if (!fits_width(SCREEN_W + H_BLANK, X_W) || !fits_width(SCREEN_H + V_BLANK, Y_W) ||
      SCREEN_W < 1 || SCREEN_H < 1 || H_BLANK < 0 || V_BLANK < 0) begin : g_bad_geometry
    $error("raster_stream_gen: screen geometry does not fit the coordinate widths");
  end

  logic [1:0] state, state_nxt;
  coord_x_t   x_cnt, x_nxt;
  coord_y_t   y_cnt, y_nxt;
  logic       transfer;
  logic       line_wrap;
  logic       frame_wrap;

  assign pixel_in_ready = (state == S_ACTIVE);
  assign transfer       = pixel_in_ready && pixel_in_valid;

  always_comb begin
    state_nxt  = state;
    x_nxt      = x_cnt;
    y_nxt      = y_cnt;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;

    case (state)
      S_IDLE: begin
        x_nxt = '0;
        y_nxt = '0;
        if (enable) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (transfer) begin
          if (x_cnt != X_ACT_LAST) begin
            x_nxt = x_cnt + 1'b1;
          end else if (HAS_HBLANK) begin
            x_nxt     = x_cnt + 1'b1;
            state_nxt = S_HBLANK;
          end else begin
            line_wrap = 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (x_cnt == X_LINE_LAST) line_wrap = 1'b1;
        else                      x_nxt     = x_cnt + 1'b1;
      end
      S_VBLANK: begin
        if (x_cnt == X_LINE_LAST) begin
          x_nxt = '0;
          if (y_cnt == Y_FRAME_LAST) frame_wrap = 1'b1;
          else                       y_nxt      = y_cnt + 1'b1;
        end else begin
          x_nxt = x_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Zero-length blanking collapses straight into the next line or the next frame.
    if (line_wrap) begin
      x_nxt = '0;
      if (y_cnt != Y_ACT_LAST) begin
        y_nxt     = y_cnt + 1'b1;
        state_nxt = S_ACTIVE;
      end else if (HAS_VBLANK) begin
        y_nxt     = y_cnt + 1'b1;
        state_nxt = S_VBLANK;
      end else begin
        frame_wrap = 1'b1;
      end
    end

    // enable is only consulted here, so a frame in flight always completes.
    if (frame_wrap) begin
      x_nxt     = '0;
      y_nxt     = '0;
      state_nxt = enable ? S_ACTIVE : S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      state <= state_nxt;
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      screen_x    <= '0;
      screen_y    <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      pixel_valid <= transfer;
      frame_start <= transfer && (x_cnt == '0) && (y_cnt == '0);
      frame_done  <= frame_wrap;
      if (transfer) begin
        pixel_out <= pixel_in;
        screen_x  <= x_cnt;
        screen_y  <= y_cnt;
      end else if (state == S_HBLANK || state == S_VBLANK) begin
        screen_x <= x_cnt;
        screen_y <= y_cnt;
      end
    end
  end

endmodule

// File: doc/raster_stream_gen.md
RASTER_STREAM_GEN -- requirements
Module: raster_stream_gen

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, active pixels per line.
REQ-002 SHALL have parameter SCREEN_H, default 240, active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 16, blank cycles appended to each line.
REQ-004 SHALL have parameter V_BLANK, default 4, blank lines appended to each frame.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  input  1  level; 1 = run frames continuously, 0 = stop at next frame boundary.
REQ-008 SHALL have port pixel_in  input  `CAMERA_PIXEL_BITWIDTH+1  upstream pixel data.
REQ-009 SHALL have port pixel_in_valid  input  1  upstream data valid.
REQ-010 SHALL have port pixel_in_ready  output  1  combinational; 1 only in ACTIVE state.
REQ-011 SHALL have port screen_x  output  `SCREEN_X_BITWIDTH+1  registered x coordinate.
REQ-012 SHALL have port screen_y  output  `SCREEN_Y_BITWIDTH+1  registered y coordinate.
REQ-013 SHALL have port pixel_out  output  `CAMERA_PIXEL_BITWIDTH+1  registered pixel.
REQ-014 SHALL have port pixel_valid  output  1  registered; pixel_out/coordinates carry an active pixel.
REQ-015 SHALL have port frame_start  output  1  one-cycle strobe with pixel (0,0).
REQ-016 SHALL have port frame_done  output  1  one-cycle strobe on last blank cycle of a frame.

Function
REQ-017 SHALL implement FSM states IDLE, ACTIVE, HBLANK, VBLANK with internal counters x_cnt, y_cnt.
REQ-018 IDLE: counters held at 0; enable=1 -> ACTIVE next cycle.
REQ-019 ACTIVE: a transfer occurs when pixel_in_valid and pixel_in_ready are both 1; with no transfer, counters and outputs hold, pixel_valid=0 (stall).
REQ-020 On transfer, next cycle: pixel_out=pixel_in, screen_x=x_cnt, screen_y=y_cnt, pixel_valid=1 (latency exactly 1 cycle); x_cnt increments.
REQ-021 Transfer at x_cnt=SCREEN_W-1 -> HBLANK with x_cnt=SCREEN_W.
REQ-022 HBLANK: x_cnt increments every cycle unconditionally, screen_x/screen_y track x_cnt/y_cnt with pixel_valid=0, so x values SCREEN_W..SCREEN_W+H_BLANK-1 are presented.
REQ-023 HBLANK end (x_cnt=SCREEN_W+H_BLANK-1): x_cnt wraps to 0, y_cnt increments; if new y_cnt<SCREEN_H -> ACTIVE, else -> VBLANK.
REQ-024 VBLANK: x_cnt free-runs 0..SCREEN_W+H_BLANK-1 per line, y_cnt runs SCREEN_H..SCREEN_H+V_BLANK-1, pixel_valid=0.
REQ-025 VBLANK last cycle (x_cnt=SCREEN_W+H_BLANK-1, y_cnt=SCREEN_H+V_BLANK-1): frame_done=1 next cycle, counters wrap to 0; enable=1 -> ACTIVE, enable=0 -> IDLE.
REQ-026 Deassertion of enable mid-frame SHALL NOT truncate the frame; it is sampled only per REQ-025.
REQ-027 frame_start SHALL assert together with pixel_valid for coordinates (0,0) only.
REQ-028 H_BLANK=0 SHALL skip HBLANK (ACTIVE at x_cnt wrap directly); V_BLANK=0 SHALL skip VBLANK with frame_done on the cycle after the last active pixel.
REQ-029 Counter comparisons SHALL use full output widths; SCREEN_W+H_BLANK and SCREEN_H+V_BLANK SHALL fit in the coordinate widths (checked by elaboration-time assertion).

Reset
REQ-030 reset=0 SHALL asynchronously force state IDLE, x_cnt=y_cnt=0, screen_x=screen_y=0, pixel_out=0, pixel_valid=0, frame_start=0, frame_done=0; pixel_in_ready=0 follows.
REQ-031 Reset mid-frame SHALL abandon the frame; after release the next frame starts at (0,0) with frame_start.

Structure
REQ-032 Coordinate and pixel widths SHALL come from network_params.h (`SCREEN_X_BITWIDTH, `SCREEN_Y_BITWIDTH, `CAMERA_PIXEL_BITWIDTH); FSM state encodings stay local.
REQ-033 SHALL be a single module; no sub-modules.

Verification
REQ-034 SCREEN_W=4, SCREEN_H=2, H_BLANK=2, V_BLANK=1, valid held 1, enable=1 -> 8 pixel_valid pulses at (0..3,0),(0..3,1), frame_done once per 18 cycles, frame_start once.
REQ-035 Same params, pixel_in_valid toggled 1/0 -> stalls hold coordinates, pixel order and values preserved, 8 pixels per frame.
REQ-036 enable dropped at pixel (1,0) -> frame completes, frame_done pulses, FSM in IDLE, pixel_in_ready=0 afterwards.
REQ-037 reset asserted at pixel (2,1) -> all outputs 0 immediately; after release and enable=1, first pixel_valid at (0,0) with frame_start=1.
REQ-038 H_BLANK=0, V_BLANK=0 -> back-to-back frames, screen_x sequence 0,1,2,3,0,... with no gaps, frame_done after each (3,1).
REQ-039 window_ctrl driven by this block, buffer at (0,0) -> buffer_rdy pulses once per frame.
